pipe_state_dump: RTL and testbench
==================================

Name: pipe_state_dump

Overview:
- Snapshot/readout unit for the pipelined CPU. On a trigger it walks the register file and the first MEM_WORDS bytes of data memory through read-only ports.
- Emits one framed snapshot on a valid/ready stream: header, registers, memory, end marker.
- Replaces per-cycle bench display logic with a parametrised, synthesizable, back-pressure-aware dumper with cycle stamping and a cycle-limit halt.

Parameters:
- DATA_W, 32, register/stream data width
- NUM_REGS, 32, registers dumped (indices 0..NUM_REGS-1)
- REG_AW, 5, register address width
- MEM_WORDS, 32, data-memory bytes dumped (addresses 0..MEM_WORDS-1)
- MEM_AW, 7, data-memory byte address width
- MEM_W, 8, data-memory word width (MEM_W <= DATA_W)
- CYC_W, 32, cycle counter width
- MAX_CYCLES, 20, cycle count at which halt_o asserts (0 = never)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- trig_i  in  1  snapshot request, sampled each rising edge
- reg_addr_o  out  REG_AW  register-file read address
- reg_data_i  in  DATA_W  register-file read data, combinational from reg_addr_o
- mem_addr_o  out  MEM_AW  data-memory read address
- mem_data_i  in  MEM_W  data-memory read data, combinational from mem_addr_o
- out_valid_o  out  1  stream beat valid
- out_ready_i  in  1  stream consumer ready
- out_tag_o  out  2  00 header, 01 register, 10 memory, 11 end
- out_idx_o  out  8  element index within the section
- out_data_o  out  DATA_W  beat payload
- busy_o  out  1  snapshot in progress
- cycle_o  out  CYC_W  free-running cycle count
- halt_o  out  1  cycle count reached MAX_CYCLES
- drop_cnt_o  out  8  triggers rejected while busy or halted

Behaviour:
- Reset (rst_i=0, async): all outputs and state are 0; FSM is IDLE. Reset mid-snapshot aborts the frame with no end marker; the stream is simply deasserted.
- cycle_o increments every edge while rst_i=1 and saturates at all-ones.
- halt_o is set when cycle_o == MAX_CYCLES-1 at an edge (i.e. cycle_o reaches MAX_CYCLES). It is sticky until reset. MAX_CYCLES=0 disables it.
- FSM states: IDLE, HDR, REG, MEM, END.
- IDLE:
  - trig_i=1 with halt_o=0 -> HDR. The header payload latches cycle_o at the trigger edge.
  - trig_i=1 with halt_o=1 -> drop_cnt_o increments (saturates at 255); stay IDLE.
- A trigger accepted while IDLE makes busy_o=1 from the next cycle. busy_o=0 only in IDLE.
- trig_i=1 in any non-IDLE state is dropped: drop_cnt_o increments (saturates); the frame is unaffected.
- Output register, single entry:
  - A beat loads when out_valid_o=0, or when out_valid_o=1 and out_ready_i=1 (same-edge replace, no bubble).
  - While out_valid_o=1 and out_ready_i=0, out_tag_o, out_idx_o and out_data_o hold stable.
  - The FSM advances only on a load.
- HDR: one beat, tag 00, idx 0, data = latched cycle count zero-extended/truncated to DATA_W -> REG.
- REG:
  - Beat k carries tag 01, idx k, data = reg_data_i with reg_addr_o=k.
  - k runs 0..NUM_REGS-1; after k=NUM_REGS-1 loads -> MEM.
- MEM:
  - Beat k carries tag 10, idx k, data = mem_data_i zero-extended, with mem_addr_o=k.
  - k runs 0..MEM_WORDS-1 -> END.
- END: one beat, tag 11, idx 0, data = NUM_REGS+MEM_WORDS -> IDLE once that beat loads. out_valid_o stays 1 until the consumer accepts it.
- A new trigger is accepted in IDLE even if the END beat is still pending. The HDR beat then loads when the END beat is accepted.
- Addresses are driven combinationally from the FSM index, so the sampled value is the one present at the load edge.
- Source contents changing during a frame are sampled as-is; no coherence guarantee.
- Latency: trigger at edge t, with out_ready_i held 1 -> header valid after t+1. The frame is NUM_REGS+MEM_WORDS+2 beats; defaults give 66 cycles, ending with the END beat loaded at t+66.

Test Plan:
- Reset, then hold rst_i=1 for 25 edges -> cycle_o=25; halt_o=1 from cycle_o=20 onward; all stream outputs 0 throughout.
- Preload r3=7 and mem[5]=0xA5, out_ready_i=1, trig_i pulse at cycle_o=2 -> header data 2; REG idx 3 data 7; MEM idx 5 data 0x000000A5; END data 64; 66 beats total; busy_o falls after END.
- Same frame with out_ready_i toggling 1,0,0,1 -> identical beat sequence; each beat stable while out_ready_i=0; no beat lost or duplicated.
- Three trig_i pulses during a frame -> drop_cnt_o=3; exactly one frame emitted.
- trig_i after halt_o=1 -> no frame emitted; drop_cnt_o increments by 1.
- Assert rst_i=0 during REG idx 10 -> out_valid_o=0 and busy_o=0 immediately; a trigger after release yields a complete frame starting at header.

Source files
------------

// File: rtl/pipe_state_dump.sv
// Snapshot dumper: on a trigger, streams header, register file, the first
// MEM_WORDS data-memory bytes and an end marker over a valid/ready port.
module pipe_state_dump #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int REG_AW     = 5,
    parameter int MEM_WORDS  = 32,
    parameter int MEM_AW     = 7,
    parameter int MEM_W      = 8,
    parameter int CYC_W      = 32,
    parameter int MAX_CYCLES = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trig_i,
    output logic [REG_AW-1:0] reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [MEM_W-1:0]  mem_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [1:0]        out_tag_o,
    output logic [7:0]        out_idx_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              busy_o,
    output logic [CYC_W-1:0]  cycle_o,
    output logic              halt_o,
    output logic [7:0]        drop_cnt_o
);

    // state  | meaning
    // S_IDLE | waiting for a trigger
    // S_HDR  | header beat pending (latched cycle count)
    // S_REG  | walking register file, idx = register number
    // S_MEM  | walking data memory, idx = byte address
    // S_END  | end-marker beat pending
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_REG, S_MEM, S_END} state_t;

    localparam logic [7:0]        REG_LAST  = 8'(NUM_REGS - 1);
    localparam logic [7:0]        MEM_LAST  = 8'(MEM_WORDS - 1);
    localparam logic [DATA_W-1:0] END_COUNT = DATA_W'(NUM_REGS + MEM_WORDS);
    localparam logic [CYC_W-1:0]  HALT_AT   = CYC_W'(MAX_CYCLES - 1);

    state_t            state, state_nxt;
    logic [7:0]        idx, idx_nxt;
    logic [CYC_W-1:0]  hdr_cyc;
    logic              load, beat_en, accept, reject;
    logic [1:0]        beat_tag;
    logic [7:0]        beat_idx;
    logic [DATA_W-1:0] beat_data;

    assign load       = !out_valid_o || out_ready_i;
    assign busy_o     = (state != S_IDLE);
    assign reg_addr_o = (state == S_REG) ? idx[REG_AW-1:0] : '0;
    assign mem_addr_o = (state == S_MEM) ? MEM_AW'(idx) : '0;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        beat_en   = 1'b0;
        beat_tag  = 2'b00;
        beat_idx  = 8'd0;
        beat_data = '0;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            S_IDLE: begin
                if (trig_i) begin
                    if (!halt_o) begin
                        accept    = 1'b1;
                        state_nxt = S_HDR;
                        idx_nxt   = 8'd0;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_HDR: begin
                reject = trig_i;
                if (load) begin
                    beat_en   = 1'b1;
                    beat_data = DATA_W'(hdr_cyc);
                    state_nxt = S_REG;
                    idx_nxt   = 8'd0;
                end
            end
            S_REG: begin
                reject = trig_i;
                if (load) begin
                    beat_en   = 1'b1;
                    beat_tag  = 2'b01;
                    beat_idx  = idx;
                    beat_data = reg_data_i;
                    if (idx == REG_LAST) begin
                        state_nxt = S_MEM;
                        idx_nxt   = 8'd0;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            S_MEM: begin
                reject = trig_i;
                if (load) begin
                    beat_en   = 1'b1;
                    beat_tag  = 2'b10;
                    beat_idx  = idx;
                    beat_data = DATA_W'(mem_data_i);
                    if (idx == MEM_LAST) begin
                        state_nxt = S_END;
                        idx_nxt   = 8'd0;
                    end else begin
                        idx_nxt = idx + 8'd1;
                    end
                end
            end
            S_END: begin
                reject = trig_i;
                if (load) begin
                    beat_en   = 1'b1;
                    beat_tag  = 2'b11;
                    beat_data = END_COUNT;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            idx   <= 8'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hdr_cyc     <= '0;
            cycle_o     <= '0;
            halt_o      <= 1'b0;
            drop_cnt_o  <= 8'd0;
            out_valid_o <= 1'b0;
            out_tag_o   <= 2'b00;
            out_idx_o   <= 8'd0;
            out_data_o  <= '0;
        end else begin
            if (accept)
                hdr_cyc <= cycle_o;
            if (reject && drop_cnt_o != 8'hFF)
                drop_cnt_o <= drop_cnt_o + 8'd1;
            if (cycle_o != '1)
                cycle_o <= cycle_o + 1'b1;
            if (MAX_CYCLES != 0 && cycle_o == HALT_AT)
                halt_o <= 1'b1;
            // A pending END beat may still drain while the FSM is back in IDLE.
            if (beat_en) begin
                out_valid_o <= 1'b1;
                out_tag_o   <= beat_tag;
                out_idx_o   <= beat_idx;
                out_data_o  <= beat_data;
            end else if (load) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_state_dump.sv
// Randomised bench for pipe_state_dump: a queue-of-beats model predicts every
// stream beat and status output; scenario checks pin the model to known values.
module tb_pipe_state_dump;

    localparam int NR   = 32;
    localparam int NM   = 32;
    localparam int MAXC = 20;

    typedef struct {
        logic [1:0]  tag;
        logic [7:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [6:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        out_valid;
    logic [1:0]  out_tag;
    logic [7:0]  out_idx;
    logic [31:0] out_data;
    logic        busy;
    logic [31:0] cycle;
    logic        halt;
    logic [7:0]  drop_cnt;

    logic [31:0] rf [NR];
    logic [7:0]  mem [NM];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign reg_data = rf[reg_addr];
    assign mem_data = (mem_addr < 7'(NM)) ? mem[mem_addr[4:0]] : 8'h00;

    pipe_state_dump dut (
        .clk_i(clk), .rst_i(rst_n), .trig_i(trig),
        .reg_addr_o(reg_addr), .reg_data_i(reg_data),
        .mem_addr_o(mem_addr), .mem_data_i(mem_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_tag_o(out_tag), .out_idx_o(out_idx), .out_data_o(out_data),
        .busy_o(busy), .cycle_o(cycle), .halt_o(halt), .drop_cnt_o(drop_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: a whole frame is queued at trigger time; one beat leaves per load.
    beat_t       mq[$];
    beat_t       m_beat;
    logic        m_valid;
    logic [31:0] m_cyc;
    logic        m_halt;
    logic [7:0]  m_drop;
    logic        busy_pre, halt_pre;
    logic [31:0] cyc_pre;

    task automatic build_frame(input logic [31:0] stamp);
        mq.push_back('{2'd0, 8'd0, stamp});
        for (int r = 0; r < NR; r++) mq.push_back('{2'd1, 8'(r), rf[r]});
        for (int m = 0; m < NM; m++) mq.push_back('{2'd2, 8'(m), {24'd0, mem[m]}});
        mq.push_back('{2'd3, 8'd0, 32'(NR + NM)});
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_valid = 1'b0;
            m_cyc   = 0;
            m_halt  = 1'b0;
            m_drop  = 0;
            m_beat  = '{2'd0, 8'd0, 32'd0};
        end else begin
            busy_pre = (mq.size() != 0);
            halt_pre = m_halt;
            cyc_pre  = m_cyc;
            if (!m_valid || out_ready) begin
                if (mq.size() != 0) begin
                    m_beat  = mq.pop_front();
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (trig) begin
                if (!busy_pre && !halt_pre) build_frame(cyc_pre);
                else if (m_drop != 8'hFF) m_drop++;
            end
            if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
            if (cyc_pre == 32'(MAXC - 1)) m_halt = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("valid", out_valid, m_valid);
            if (m_valid) begin
                check("tag", out_tag, m_beat.tag);
                check("idx", out_idx, m_beat.idx);
                check("data", out_data, m_beat.data);
            end
            check("busy", busy, mq.size() != 0);
            check("cycle", cycle, m_cyc);
            check("halt", halt, m_halt);
            check("drop", drop_cnt, m_drop);
        end
    end

    beat_t log_q[$];
    beat_t ref_q[$];
    always @(posedge clk)
        if (rst_n && out_valid && out_ready) log_q.push_back('{out_tag, out_idx, out_data});

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        trig = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input int mode, input int max_cyc);
        bit done = 0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge clk);
            trig = 1'b0;
            if (mode == 1) out_ready = (k % 4 == 0) || (k % 4 == 3);
            else if (mode == 2) begin
                out_ready = ($urandom_range(0, 3) != 0);
                trig = ($urandom_range(0, 15) == 0);
            end else out_ready = 1'b1;
            if (k > 2 && !busy && !out_valid) done = 1;
        end
        trig = 1'b0;
        out_ready = 1'b1;
        check("frame_done", done, 1);
    endtask

    task automatic fill_random();
        for (int r = 0; r < NR; r++) rf[r] = $urandom;
        for (int m = 0; m < NM; m++) mem[m] = 8'($urandom);
    endtask

    initial begin
        int nmis;
        int nhdr;
        fill_random();

        // idle run past the halt point
        do_reset();
        repeat (25) @(negedge clk);
        check("cycle_25", cycle, 32'd25);
        check("halt_25", halt, 1);
        check("idle_valid", out_valid, 0);
        check("idle_data", out_data, 0);

        // plain frame, trigger at cycle 2
        fill_random();
        rf[3] = 32'd7;
        mem[5] = 8'hA5;
        do_reset();
        log_q.delete();
        @(negedge clk);
        @(negedge clk);
        trig = 1'b1;
        run_frame(0, 200);
        check("beats", log_q.size(), 66);
        if (log_q.size() == 66) begin
            check("hdr_data", log_q[0].data, 32'd2);
            check("hdr_tag", log_q[0].tag, 2'd0);
            check("r3_idx", log_q[4].idx, 8'd3);
            check("r3_data", log_q[4].data, 32'd7);
            check("m5_tag", log_q[38].tag, 2'd2);
            check("m5_data", log_q[38].data, 32'h0000_00A5);
            check("end_tag", log_q[65].tag, 2'd3);
            check("end_data", log_q[65].data, 32'd64);
        end
        ref_q = log_q;

        // same frame under back-pressure 1,0,0,1
        do_reset();
        log_q.delete();
        @(negedge clk);
        @(negedge clk);
        trig = 1'b1;
        run_frame(1, 400);
        check("bp_beats", log_q.size(), 66);
        nmis = 0;
        for (int i = 0; i < 66 && i < log_q.size() && i < ref_q.size(); i++)
            if (log_q[i] != ref_q[i]) nmis++;
        check("bp_sequence", nmis, 0);

        // triggers during a frame are dropped
        do_reset();
        log_q.delete();
        trig = 1'b1;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            trig = 1'b0;
            repeat (3) @(negedge clk);
            trig = 1'b1;
        end
        run_frame(0, 200);
        check("drop_3", drop_cnt, 8'd3);
        check("one_frame", log_q.size(), 66);
        nhdr = 0;
        foreach (log_q[i]) if (log_q[i].tag == 2'd0) nhdr++;
        check("one_header", nhdr, 1);

        // trigger after halt is rejected
        log_q.delete();
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        repeat (5) @(negedge clk);
        check("halt_drop", drop_cnt, 8'd4);
        check("halt_no_frame", log_q.size(), 0);
        check("halt_busy", busy, 0);

        // reset in the middle of the register section
        do_reset();
        trig = 1'b1;
        begin
            bit seen = 0;
            for (int k = 0; k < 100 && !seen; k++) begin
                @(negedge clk);
                trig = 1'b0;
                if (out_valid && out_tag == 2'd1 && out_idx == 8'd10) seen = 1;
            end
            check("reached_reg10", seen, 1);
        end
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        trig = 1'b1;
        run_frame(0, 200);
        check("restart_beats", log_q.size(), 66);
        if (log_q.size() > 0) check("restart_hdr", log_q[0].tag, 2'd0);

        // randomised frames
        for (int n = 0; n < 3; n++) begin
            fill_random();
            do_reset();
            log_q.delete();
            repeat ($urandom_range(0, 5)) @(negedge clk);
            trig = 1'b1;
            run_frame(2, 600);
            check("rand_beats", log_q.size(), 66);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
